// File: rtl/datapath_param.sv
// Parametrised CPU datapath: bus mux, register file, PC/IR, MAR/MDR, Y/Z, HI/LO, I/O ports,
// bus-conflict detection and a req/ack memory handshake FSM.
module datapath_param #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned ADDR_W   = 9
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  pci,
  input  logic                  pco,
  input  logic [DATA_W-1:0]     pc_in,
  input  logic                  iri,
  input  logic                  iro,
  input  logic                  mari,
  input  logic                  mdri,
  input  logic                  mdro,
  input  logic                  hii,
  input  logic                  hio,
  input  logic                  loi,
  input  logic                  loo,
  input  logic                  ryi,
  input  logic                  rzi,
  input  logic                  rzho,
  input  logic                  rzlo,
  input  logic                  opi,
  input  logic                  ipi,
  input  logic                  ipo,
  input  logic [DATA_W-1:0]     in_port,
  input  logic                  gra,
  input  logic                  grb,
  input  logic                  grc,
  input  logic                  rin,
  input  logic                  rout,
  input  logic                  baout,
  input  logic                  csigno,
  input  logic                  mem_rd,
  input  logic                  mem_wr,
  input  logic [2*DATA_W-1:0]   alu_result,
  input  logic                  mem_ack,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [DATA_W-1:0]     bus,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  output logic [4:0]            opcode,
  output logic [DATA_W-1:0]     out_port,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic                  mem_busy,
  output logic                  mem_done,
  output logic                  bus_err
);

  localparam int unsigned RS_W = $clog2(NUM_REGS);
  localparam int unsigned C_W  = DATA_W - 5 - 2 * RS_W;
  localparam int unsigned Z_W  = 2 * DATA_W;
  localparam int unsigned NDRV = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  logic [DATA_W-1:0] r_pc, r_ir, r_mar, r_mdr, r_hi, r_lo, r_y, r_out, r_in;
  logic [Z_W-1:0]    r_z;
  logic [DATA_W-1:0] r_regs [NUM_REGS];
  mem_state_e        r_state, w_state_nxt;
  logic              r_dir, w_dir_nxt;
  logic              w_capture;

  logic [RS_W-1:0]   w_ra, w_rb, w_rc, w_sel;
  logic [DATA_W-1:0] w_c, w_reg_val, w_bus;
  logic              w_reg_drv;
  logic [NDRV-1:0]   w_drv;
  logic              w_bus_err;
  logic              w_unused;

  // IR field decode and register select
  assign w_ra  = r_ir[DATA_W-6 -: RS_W];
  assign w_rb  = r_ir[DATA_W-6-RS_W -: RS_W];
  assign w_rc  = r_ir[DATA_W-6-2*RS_W -: RS_W];
  assign w_c   = {{(DATA_W-C_W){r_ir[C_W-1]}}, r_ir[C_W-1:0]};
  assign w_sel = ({RS_W{gra}} & w_ra) | ({RS_W{grb}} & w_rb) | ({RS_W{grc}} & w_rc);

  assign w_reg_drv = rout | baout;
  assign w_reg_val = (baout && (w_sel == '0)) ? '0 : r_regs[w_sel];

  // A conflicted bus reads as zero so no register can latch a mixed value
  assign w_drv     = {pco, iro, mdro, hio, loo, rzho, rzlo, ipo, csigno, w_reg_drv};
  assign w_bus_err = ($countones(w_drv) > 1);

  always_comb begin
    w_bus = ({DATA_W{pco}}       & r_pc)
          | ({DATA_W{iro}}       & r_ir)
          | ({DATA_W{mdro}}      & r_mdr)
          | ({DATA_W{hio}}       & r_hi)
          | ({DATA_W{loo}}       & r_lo)
          | ({DATA_W{rzho}}      & r_z[Z_W-1:DATA_W])
          | ({DATA_W{rzlo}}      & r_z[DATA_W-1:0])
          | ({DATA_W{ipo}}       & r_in)
          | ({DATA_W{csigno}}    & w_c)
          | ({DATA_W{w_reg_drv}} & w_reg_val);
    if (w_bus_err) w_bus = '0;
  end

  assign bus       = w_bus;
  assign bus_err   = w_bus_err;
  assign alu_a     = r_y;
  assign alu_b     = w_bus;
  assign opcode    = r_ir[DATA_W-1 -: 5];
  assign out_port  = r_out;
  assign mem_addr  = r_mar[ADDR_W-1:0];
  assign mem_wdata = r_mdr;
  assign w_unused  = ^r_mar[DATA_W-1:ADDR_W];

  // Memory handshake state register
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state <= ST_IDLE;
      r_dir   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_dir   <= w_dir_nxt;
    end
  end

  // Memory handshake next-state and outputs; r_dir = 1 means write
  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir;
    w_capture   = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_busy    = 1'b0;
    mem_done    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (mem_rd ^ mem_wr) begin
          w_state_nxt = ST_REQ;
          w_dir_nxt   = mem_wr;
        end
      end
      ST_REQ: begin
        mem_req  = 1'b1;
        mem_we   = r_dir;
        mem_busy = 1'b1;
        if (mem_ack) begin
          w_state_nxt = ST_DONE;
          w_capture   = ~r_dir;
        end
      end
      ST_DONE: begin
        mem_done    = 1'b1;
        mem_busy    = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_pc  <= '0;
      r_ir  <= '0;
      r_mar <= '0;
      r_mdr <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_y   <= '0;
      r_z   <= '0;
      r_out <= '0;
      r_in  <= '0;
    end else begin
      if (pci)  r_pc  <= pc_in;
      if (iri)  r_ir  <= w_bus;
      if (mari) r_mar <= w_bus;
      if (w_capture)  r_mdr <= mem_rdata;
      else if (mdri)  r_mdr <= w_bus;
      if (hii)  r_hi  <= r_z[Z_W-1:DATA_W];
      if (loi)  r_lo  <= r_z[DATA_W-1:0];
      if (ryi)  r_y   <= w_bus;
      if (rzi)  r_z   <= alu_result;
      if (opi)  r_out <= w_bus;
      if (ipi)  r_in  <= in_port;
    end
  end

  // General register file
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (rin) begin
      r_regs[w_sel] <= w_bus;
    end
  end

endmodule

// File: tb/tb_datapath_param.sv
// Bench for datapath_param: directed scenarios followed by random control words,
// checked every cycle against a behavioural model of the datapath.
module tb_datapath_param;

  logic        clock = 1'b0;
  logic        clear;
  logic        pci, pco, iri, iro, mari, mdri, mdro, hii, hio, loi, loo, ryi, rzi;
  logic        rzho, rzlo, opi, ipi, ipo, gra, grb, grc, rin, rout, baout, csigno;
  logic        mem_rd, mem_wr, mem_ack;
  logic [31:0] pc_in, in_port, mem_rdata;
  logic [63:0] alu_result;
  logic [31:0] bus, alu_a, alu_b, out_port, mem_wdata;
  logic [4:0]  opcode;
  logic [8:0]  mem_addr;
  logic        mem_req, mem_we, mem_busy, mem_done, bus_err;

  int errors = 0;
  int checks = 0;
  int req_cycles;

  // Behavioural model state
  logic [31:0] m_pc, m_ir, m_mar, m_mdr, m_hi, m_lo, m_y, m_out, m_in;
  logic [63:0] m_z;
  logic [31:0] m_regs [16];
  int          m_phase;
  logic        m_rd;

  datapath_param dut (
    .clock(clock), .clear(clear), .pci(pci), .pco(pco), .pc_in(pc_in),
    .iri(iri), .iro(iro), .mari(mari), .mdri(mdri), .mdro(mdro),
    .hii(hii), .hio(hio), .loi(loi), .loo(loo), .ryi(ryi), .rzi(rzi),
    .rzho(rzho), .rzlo(rzlo), .opi(opi), .ipi(ipi), .ipo(ipo), .in_port(in_port),
    .gra(gra), .grb(grb), .grc(grc), .rin(rin), .rout(rout), .baout(baout),
    .csigno(csigno), .mem_rd(mem_rd), .mem_wr(mem_wr), .alu_result(alu_result),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .bus(bus), .alu_a(alu_a),
    .alu_b(alu_b), .opcode(opcode), .out_port(out_port), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_busy(mem_busy), .mem_done(mem_done), .bus_err(bus_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    {pci, pco, iri, iro, mari, mdri, mdro, hii, hio, loi, loo, ryi, rzi} = '0;
    {rzho, rzlo, opi, ipi, ipo, gra, grb, grc, rin, rout, baout, csigno} = '0;
    {mem_rd, mem_wr, mem_ack} = '0;
    pc_in = '0; in_port = '0; mem_rdata = '0; alu_result = '0;
  endtask

  task automatic model_reset();
    {m_pc, m_ir, m_mar, m_mdr, m_hi, m_lo, m_y, m_out, m_in} = '0;
    m_z = '0;
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_phase = 0;
    m_rd = 1'b0;
  endtask

  function automatic logic [3:0] model_sel();
    logic [3:0] s;
    s = 4'h0;
    if (gra) s = s | m_ir[26:23];
    if (grb) s = s | m_ir[22:19];
    if (grc) s = s | m_ir[18:15];
    return s;
  endfunction

  // Returns {conflict, bus value}: collect every enabled source, keep it only if it is alone
  function automatic logic [32:0] model_bus();
    logic [31:0] srcs[$];
    logic [31:0] c;
    c = 32'($signed(m_ir[18:0]));
    if (pco)    srcs.push_back(m_pc);
    if (iro)    srcs.push_back(m_ir);
    if (mdro)   srcs.push_back(m_mdr);
    if (hio)    srcs.push_back(m_hi);
    if (loo)    srcs.push_back(m_lo);
    if (rzho)   srcs.push_back(m_z[63:32]);
    if (rzlo)   srcs.push_back(m_z[31:0]);
    if (ipo)    srcs.push_back(m_in);
    if (csigno) srcs.push_back(c);
    if (rout || baout)
      srcs.push_back((baout && model_sel() == 4'h0) ? 32'h0 : m_regs[model_sel()]);
    if (srcs.size() == 1) return {1'b0, srcs[0]};
    return {srcs.size() > 1, 32'h0};
  endfunction

  task automatic model_edge();
    logic [32:0] eb;
    logic [31:0] b;
    logic [3:0]  s;
    eb = model_bus();
    b  = eb[31:0];
    s  = model_sel();
    if (rin)  m_regs[s] = b;
    if (hii)  m_hi = m_z[63:32];
    if (loi)  m_lo = m_z[31:0];
    if (rzi)  m_z  = alu_result;
    if (pci)  m_pc = pc_in;
    if (iri)  m_ir = b;
    if (mari) m_mar = b;
    if (ryi)  m_y = b;
    if (opi)  m_out = b;
    if (ipi)  m_in = in_port;
    if (mdri) m_mdr = b;
    case (m_phase)
      0: if (mem_rd != mem_wr) begin m_phase = 1; m_rd = mem_rd; end
      1: if (mem_ack) begin
           if (m_rd) m_mdr = mem_rdata;
           m_phase = 2;
         end
      default: m_phase = 0;
    endcase
  endtask

  task automatic check_all(input string tag);
    logic [32:0] eb;
    eb = model_bus();
    chk({tag, ".bus"},      bus,       eb[31:0]);
    chk({tag, ".bus_err"},  bus_err,   eb[32]);
    chk({tag, ".alu_b"},    alu_b,     eb[31:0]);
    chk({tag, ".alu_a"},    alu_a,     m_y);
    chk({tag, ".opcode"},   opcode,    m_ir[31:27]);
    chk({tag, ".out_port"}, out_port,  m_out);
    chk({tag, ".mem_req"},  mem_req,   m_phase == 1);
    chk({tag, ".mem_we"},   mem_we,    (m_phase == 1) && !m_rd);
    chk({tag, ".mem_busy"}, mem_busy,  m_phase != 0);
    chk({tag, ".mem_done"}, mem_done,  m_phase == 2);
    chk({tag, ".mem_addr"}, mem_addr,  m_mar[8:0]);
    chk({tag, ".mdr"},      mem_wdata, m_mdr);
  endtask

  // Called right after a falling edge with inputs applied: check, advance model, clock
  task automatic tick(input string tag);
    #1;
    check_all(tag);
    model_edge();
    @(posedge clock);
    #1;
    @(negedge clock);
  endtask

  initial begin
    idle();
    clear = 1'b0;
    model_reset();
    #2;
    check_all("reset");
    @(negedge clock);
    clear = 1'b1;

    // Reset while a read is outstanding aborts it at once
    idle(); pc_in = 32'hDEAD_BEEF; pci = 1; tick("t1a");
    idle(); pco = 1; mdri = 1; tick("t1b");
    idle(); mem_rd = 1; tick("t1c");
    idle(); #1;
    chk("t1.req_live", mem_req, 1'b1);
    clear = 1'b0; model_reset(); #1;
    chk("t1.req_abort", mem_req, 1'b0);
    chk("t1.busy_abort", mem_busy, 1'b0);
    mdro = 1; #1;
    chk("t1.mdr_zero", bus, 32'h0);
    mdro = 0; pco = 1; #1;
    chk("t1.pc_zero", bus, 32'h0);
    pco = 0;
    @(negedge clock);
    clear = 1'b1;

    // Sign-extended constant into R3, then baout on R0
    idle(); pc_in = 32'h0187_FFFB; pci = 1; tick("t2a");
    idle(); pco = 1; iri = 1; tick("t2b");
    idle(); csigno = 1; gra = 1; rin = 1; tick("t2c");
    idle(); gra = 1; rout = 1; #1;
    chk("t2.r3", bus, 32'hFFFF_FFFB); tick("t2d");
    idle(); grb = 1; baout = 1; #1;
    chk("t2.ba_r0", bus, 32'h0); tick("t2e");
    idle(); pc_in = 32'h0000_0777; pci = 1; tick("t2f");
    idle(); pco = 1; grb = 1; rin = 1; tick("t2g");
    idle(); grb = 1; baout = 1; #1;
    chk("t2.ba_r0_written", bus, 32'h0); tick("t2h");
    idle(); grb = 1; rout = 1; #1;
    chk("t2.r0_read", bus, 32'h0000_0777); tick("t2i");

    // Two drivers collide
    idle(); pc_in = 32'd4; pci = 1; tick("t3a");
    idle(); pco = 1; mdro = 1; ryi = 1; #1;
    chk("t3.conflict_bus", bus, 32'h0);
    chk("t3.conflict_err", bus_err, 1'b1); tick("t3b");
    idle(); pco = 1; #1;
    chk("t3.pc_bus", bus, 32'd4);
    chk("t3.pc_err", bus_err, 1'b0); tick("t3c");

    // Write with two wait cycles, read command while busy dropped
    idle(); pc_in = 32'h0000_01FF; pci = 1; tick("t4a");
    idle(); pco = 1; mari = 1; tick("t4b");
    idle(); pc_in = 32'hA5A5_A5A5; pci = 1; tick("t4c");
    idle(); pco = 1; mdri = 1; tick("t4d");
    idle(); mem_wr = 1; tick("t4e");
    req_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      idle(); mem_rd = (i == 0); mem_ack = (i == 2); #1;
      if (mem_req && mem_we) req_cycles++;
      chk("t4.addr", mem_addr, 9'h1FF);
      chk("t4.wdata", mem_wdata, 32'hA5A5_A5A5);
      tick("t4w");
    end
    chk("t4.req_cycles", req_cycles, 3);
    idle(); mem_rd = 1; #1;
    chk("t4.done", mem_done, 1'b1); tick("t4f");
    idle(); #1;
    chk("t4.after_req", mem_req, 1'b0);
    chk("t4.after_done", mem_done, 1'b0); tick("t4g");

    // Zero-wait read, then simultaneous commands
    idle(); mem_rd = 1; tick("t5a");
    idle(); mem_ack = 1; mem_rdata = 32'h1234_5678; #1;
    chk("t5.req", mem_req, 1'b1);
    chk("t5.we", mem_we, 1'b0); tick("t5b");
    chk("t5.mdr", mem_wdata, 32'h1234_5678);
    idle(); #1;
    chk("t5.done", mem_done, 1'b1); tick("t5c");
    idle(); mem_rd = 1; mem_wr = 1; tick("t5d");
    idle(); #1;
    chk("t5.both_req", mem_req, 1'b0);
    chk("t5.both_busy", mem_busy, 1'b0); tick("t5e");

    // Z into HI/LO
    idle(); alu_result = 64'h0000_0001_0000_0002; rzi = 1; tick("t6a");
    idle(); hii = 1; loi = 1; tick("t6b");
    idle(); hio = 1; #1;
    chk("t6.hi", bus, 32'd1); tick("t6c");
    idle(); loo = 1; #1;
    chk("t6.lo", bus, 32'd2); tick("t6d");

    // Random control words
    for (int n = 0; n < 400; n++) begin
      idle();
      pco = ($urandom_range(0, 9) == 0);    iro  = ($urandom_range(0, 9) == 0);
      mdro = ($urandom_range(0, 9) == 0);   hio  = ($urandom_range(0, 9) == 0);
      loo = ($urandom_range(0, 9) == 0);    rzho = ($urandom_range(0, 9) == 0);
      rzlo = ($urandom_range(0, 9) == 0);   ipo  = ($urandom_range(0, 9) == 0);
      csigno = ($urandom_range(0, 9) == 0); rout = ($urandom_range(0, 9) == 0);
      baout = ($urandom_range(0, 9) == 0);
      gra = ($urandom_range(0, 1) == 0);    grb = ($urandom_range(0, 2) == 0);
      grc = ($urandom_range(0, 2) == 0);
      pci = ($urandom_range(0, 2) == 0);    iri  = ($urandom_range(0, 3) == 0);
      mari = ($urandom_range(0, 3) == 0);   mdri = ($urandom_range(0, 3) == 0);
      hii = ($urandom_range(0, 3) == 0);    loi  = ($urandom_range(0, 3) == 0);
      ryi = ($urandom_range(0, 3) == 0);    rzi  = ($urandom_range(0, 3) == 0);
      opi = ($urandom_range(0, 3) == 0);    ipi  = ($urandom_range(0, 3) == 0);
      rin = ($urandom_range(0, 2) == 0);
      mem_rd = ($urandom_range(0, 5) == 0); mem_wr = ($urandom_range(0, 5) == 0);
      mem_ack = ($urandom_range(0, 2) == 0);
      pc_in = $urandom; in_port = $urandom; mem_rdata = $urandom;
      alu_result = {$urandom, $urandom};
      tick("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
